// File: rtl/swd_txn_ctrl.sv
// SWD transaction sequencer: turns DP/AP register requests and line resets into
// PHY command words, then decodes the ACK/data response, retrying on WAIT.
module swd_txn_ctrl #(
  parameter int OWIDTH    = 64,
  parameter int IWIDTH    = 38,
  parameter int RETRY_MAX = 15
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               REQ_VALID,
  output logic                               REQ_READY,
  input  logic                               REQ_LINERST,
  input  logic                               REQ_APNDP,
  input  logic                               REQ_RNW,
  input  logic [1:0]                         REQ_ADDR,
  input  logic [31:0]                        REQ_WDATA,
  output logic                               RSP_VALID,
  input  logic                               RSP_READY,
  output logic [2:0]                         RSP_STATUS,
  output logic [31:0]                        RSP_RDATA,
  output logic [OWIDTH+3*$clog2(OWIDTH)-1:0] PHY_WRDATA,
  output logic                               PHY_WREN,
  input  logic                               PHY_WRFULL,
  input  logic [IWIDTH+$clog2(IWIDTH)-2:0]   PHY_RDDATA,
  output logic                               PHY_RDEN,
  input  logic                               PHY_RDEMPTY
);

  localparam int LW = $clog2(OWIDTH);
  localparam int CW = OWIDTH + 3 * LW;
  localparam int NW = $clog2(IWIDTH);
  localparam int RW = IWIDTH + NW - 1;
  localparam int BW = IWIDTH - 1;

  localparam logic [3:0]    RETRY_LIMIT = 4'(RETRY_MAX);
  localparam logic [NW-1:0] READ_CNT    = NW'(36);
  localparam logic [NW-1:0] WRITE_CNT   = NW'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAITRSP,
    S_POP,
    S_CAPTURE,
    S_DECODE,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    ST_OK     = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FAULT  = 3'd2,
    ST_PARITY = 3'd3,
    ST_NOACK  = 3'd4
  } status_t;

  state_t        state;
  logic [CW-1:0] cmd_word;
  logic          is_read;
  logic          is_linerst;
  logic [3:0]    retry_cnt;
  logic [RW-1:0] rsp_word;

  logic [BW-1:0] rsp_bits;
  logic [NW-1:0] rsp_cnt;
  logic [2:0]    ack;
  logic [31:0]   rd_data;
  logic          rd_par;
  status_t       dec_status;
  logic [31:0]   dec_data;
  logic          dec_retry;
  logic          unused_bits;

  // Header is sent LSB first: start, APnDP, RnW, A2, A3, parity, stop, park.
  function automatic logic [CW-1:0] build_cmd(
    input logic        linerst,
    input logic        apndp,
    input logic        rnw,
    input logic [1:0]  addr,
    input logic [31:0] wdata
  );
    logic [OWIDTH-1:0] so;
    logic [LW-1:0]     len;
    logic [LW-1:0]     t0;
    logic [LW-1:0]     t1;
    logic              par;
    so  = '0;
    len = '0;
    t0  = '0;
    t1  = '0;
    par = apndp ^ rnw ^ addr[0] ^ addr[1];
    if (linerst) begin
      len       = LW'(60);
      t0        = LW'(63);
      t1        = LW'(63);
      so[51:0]  = '1;
    end else begin
      so[7:0] = {1'b1, 1'b0, par, addr[1], addr[0], rnw, apndp, 1'b1};
      len     = LW'(46);
      t0      = LW'(8);
      if (rnw) begin
        t1 = LW'(45);
      end else begin
        t1         = LW'(12);
        so[45:13]  = {^wdata, wdata};
      end
    end
    return {len, t0, t1, so};
  endfunction

  assign rsp_bits    = rsp_word[RW-1:NW];
  assign rsp_cnt     = rsp_word[NW-1:0];
  assign unused_bits = rsp_bits[BW-1];

  // The PHY shifts in from the bottom, so the first wire bit lands highest.
  always_comb begin
    ack        = is_read ? {rsp_bits[33], rsp_bits[34], rsp_bits[35]}
                         : {rsp_bits[0], rsp_bits[1], rsp_bits[2]};
    rd_data    = '0;
    for (int i = 0; i < 32; i++) begin
      rd_data[i] = rsp_bits[32-i];
    end
    rd_par     = rsp_bits[0];
    dec_status = ST_NOACK;
    dec_data   = '0;
    dec_retry  = 1'b0;
    if (rsp_cnt == (is_read ? READ_CNT : WRITE_CNT)) begin
      case (ack)
        3'b001: begin
          if (is_read && (rd_par != ^rd_data)) begin
            dec_status = ST_PARITY;
          end else begin
            dec_status = ST_OK;
            if (is_read) dec_data = rd_data;
          end
        end
        3'b010: begin
          if (retry_cnt < RETRY_LIMIT) dec_retry = 1'b1;
          else dec_status = ST_WAIT;
        end
        3'b100:  dec_status = ST_FAULT;
        default: dec_status = ST_NOACK;
      endcase
    end
  end

  // The command word is built once at accept time and re-pushed verbatim on WAIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cmd_word   <= '0;
      is_read    <= 1'b0;
      is_linerst <= 1'b0;
      retry_cnt  <= '0;
      rsp_word   <= '0;
      REQ_READY  <= 1'b1;
      RSP_VALID  <= 1'b0;
      RSP_STATUS <= '0;
      RSP_RDATA  <= '0;
      PHY_WRDATA <= '0;
      PHY_WREN   <= 1'b0;
      PHY_RDEN   <= 1'b0;
    end else begin
      PHY_WREN <= 1'b0;
      PHY_RDEN <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            cmd_word   <= build_cmd(REQ_LINERST, REQ_APNDP, REQ_RNW, REQ_ADDR, REQ_WDATA);
            is_read    <= REQ_RNW && !REQ_LINERST;
            is_linerst <= REQ_LINERST;
            REQ_READY  <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!PHY_WRFULL) begin
            PHY_WREN   <= 1'b1;
            PHY_WRDATA <= cmd_word;
            if (is_linerst) begin
              RSP_VALID  <= 1'b1;
              RSP_STATUS <= ST_OK;
              RSP_RDATA  <= '0;
              state      <= S_DONE;
            end else begin
              state <= S_WAITRSP;
            end
          end
        end
        S_WAITRSP: begin
          if (!PHY_RDEMPTY) begin
            PHY_RDEN <= 1'b1;
            state    <= S_POP;
          end
        end
        S_POP: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_word <= PHY_RDDATA;
          state    <= S_DECODE;
        end
        S_DECODE: begin
          if (dec_retry) begin
            retry_cnt <= retry_cnt + 4'd1;
            state     <= S_ISSUE;
          end else begin
            RSP_VALID  <= 1'b1;
            RSP_STATUS <= dec_status;
            RSP_RDATA  <= dec_data;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            retry_cnt <= '0;
            REQ_READY <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swd_txn_ctrl.sv
// Directed bench for swd_txn_ctrl: a vector table of complete transactions
// plus hand-written FIFO-full, reset and same-cycle handshake sequences.
module tb_swd_txn_ctrl;

  logic        CLK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_LINERST;
  logic        REQ_APNDP;
  logic        REQ_RNW;
  logic [1:0]  REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [2:0]  RSP_STATUS;
  logic [31:0] RSP_RDATA;
  logic [81:0] PHY_WRDATA;
  logic        PHY_WREN;
  logic        PHY_WRFULL;
  logic [42:0] PHY_RDDATA;
  logic        PHY_RDEN;
  logic        PHY_RDEMPTY;

  int tests_run;
  int tests_failed;
  int proto_err;

  swd_txn_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_LINERST(REQ_LINERST),
    .REQ_APNDP(REQ_APNDP), .REQ_RNW(REQ_RNW), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_STATUS(RSP_STATUS), .RSP_RDATA(RSP_RDATA),
    .PHY_WRDATA(PHY_WRDATA), .PHY_WREN(PHY_WREN), .PHY_WRFULL(PHY_WRFULL),
    .PHY_RDDATA(PHY_RDDATA), .PHY_RDEN(PHY_RDEN), .PHY_RDEMPTY(PHY_RDEMPTY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (PHY_WREN && PHY_WRFULL) proto_err++;
    if (PHY_RDEN && PHY_RDEMPTY) proto_err++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Hand-computed command words {len, t0, t1, so}.
  localparam logic [81:0] RD_DP0 = {6'd46, 6'd8, 6'd45, 64'h0000_0000_0000_00A5};
  localparam logic [81:0] RD_AP3 = {6'd46, 6'd8, 6'd45, 64'h0000_0000_0000_009F};
  localparam logic [81:0] WR_AP1 = {6'd46, 6'd8, 6'd12, 64'h0000_0460_000A_408B};
  localparam logic [81:0] WR_DP2 = {6'd46, 6'd8, 6'd12, 64'h0000_2000_001E_20B1};
  localparam logic [81:0] LR_CMD = {6'd60, 6'd63, 6'd63, 64'h000F_FFFF_FFFF_FFFF};

  // PHY response words in wire order: ack bits first, then data LSB first, then parity.
  function automatic logic [42:0] read_rsp(input logic [2:0] a, input logic [31:0] data, input logic flip);
    logic [36:0] b;
    b     = '0;
    b[35] = a[0];
    b[34] = a[1];
    b[33] = a[2];
    for (int i = 0; i < 32; i++) b[32-i] = data[i];
    b[0]  = (^data) ^ flip;
    return {b, 6'd36};
  endfunction

  function automatic logic [42:0] write_rsp(input logic [2:0] a);
    logic [36:0] b;
    b    = '0;
    b[2] = a[0];
    b[1] = a[1];
    b[0] = a[2];
    return {b, 6'd3};
  endfunction

  typedef struct {
    logic        lr;
    logic        apndp;
    logic        rnw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    int          nwait;
    logic [42:0] wait_rsp;
    logic [42:0] final_rsp;
    logic [81:0] exp_cmd;
    logic [2:0]  exp_status;
    logic [31:0] exp_rdata;
    int          exp_pushes;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [81:0] act, input logic [81:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_req(input string tag, input logic lr, input logic apndp, input logic rnw,
                          input logic [1:0] addr, input logic [31:0] wdata);
    @(negedge CLK);
    checkOutput({tag, " ready"}, 82'(REQ_READY), 82'(1));
    REQ_LINERST = lr;
    REQ_APNDP   = apndp;
    REQ_RNW     = rnw;
    REQ_ADDR    = addr;
    REQ_WDATA   = wdata;
    REQ_VALID   = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    checkOutput({tag, " busy"}, 82'(REQ_READY), 82'(0));
  endtask

  // Acts as the PHY: answers each pushed command, pops on RDEN, stops at RSP_VALID.
  task automatic service_txn(input string tag, input int nwait, input logic [42:0] wait_rsp,
                             input logic [42:0] final_rsp, input logic [81:0] exp_cmd, input logic lr,
                             output int pushes, output int first_cyc, output int rsp_cyc, output int rdens);
    int rsp_idx;
    bit done;
    pushes = 0; first_cyc = -1; rsp_cyc = -1; rdens = 0; rsp_idx = 0; done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge CLK);
      if (PHY_WREN) begin
        if (pushes == 0) first_cyc = cyc;
        pushes++;
        checkOutput($sformatf("%s cmd%0d", tag, pushes), PHY_WRDATA, exp_cmd);
        if (!lr) begin
          PHY_RDDATA  = (rsp_idx < nwait) ? wait_rsp : final_rsp;
          PHY_RDEMPTY = 1'b0;
          rsp_idx++;
        end
      end
      if (PHY_RDEN) begin
        rdens++;
        @(posedge CLK);
        #1 PHY_RDEMPTY = 1'b1;
      end
      if (RSP_VALID) begin
        rsp_cyc = cyc;
        done    = 1;
      end
    end
    checkOutput({tag, " rsp seen"}, 82'(done), 82'(1));
  endtask

  task automatic complete_rsp(input string tag);
    repeat (2) @(negedge CLK);
    checkOutput({tag, " rsp held"}, 82'(RSP_VALID), 82'(1));
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
    checkOutput({tag, " rsp cleared"}, 82'(RSP_VALID), 82'(0));
    checkOutput({tag, " ready again"}, 82'(REQ_READY), 82'(1));
  endtask

  task automatic applyStimulus(input int i);
    string tag;
    int pushes, first_cyc, rsp_cyc, rdens;
    tag = $sformatf("vec%0d", i);
    send_req(tag, vecs[i].lr, vecs[i].apndp, vecs[i].rnw, vecs[i].addr, vecs[i].wdata);
    service_txn(tag, vecs[i].nwait, vecs[i].wait_rsp, vecs[i].final_rsp, vecs[i].exp_cmd, vecs[i].lr,
                pushes, first_cyc, rsp_cyc, rdens);
    checkOutput({tag, " pushes"}, 82'(pushes), 82'(vecs[i].exp_pushes));
    checkOutput({tag, " first push"}, 82'(first_cyc), 82'(0));
    checkOutput({tag, " pops"}, 82'(rdens), vecs[i].lr ? 82'(0) : 82'(vecs[i].exp_pushes));
    checkOutput({tag, " status"}, 82'(RSP_STATUS), 82'(vecs[i].exp_status));
    checkOutput({tag, " rdata"}, 82'(RSP_RDATA), 82'(vecs[i].exp_rdata));
    if (vecs[i].lr) checkOutput({tag, " rsp latency ok"}, 82'(rsp_cyc >= 0 && rsp_cyc <= 2), 82'(1));
    complete_rsp(tag);
  endtask

  initial begin
    int pushes, first_cyc, rsp_cyc, rdens, early;
    bit seen;
    tests_run = 0; tests_failed = 0; proto_err = 0;
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_LINERST = 1'b0; REQ_APNDP = 1'b0; REQ_RNW = 1'b0;
    REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b0; PHY_WRFULL = 1'b0;
    PHY_RDDATA = '0; PHY_RDEMPTY = 1'b1;

    //            lr    apndp rnw   addr  wdata          nwait wait_rsp                  final_rsp                                exp_cmd exp_st exp_rdata      pushes
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         0,  read_rsp(3'b010, 0, 0), read_rsp(3'b001, 32'h2BA01477, 0), RD_DP0, 3'd0, 32'h2BA01477, 1};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 0,  read_rsp(3'b010, 0, 0), read_rsp(3'b001, 32'h0, 0),        LR_CMD, 3'd0, 32'h0,         1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h23000052,  0,  write_rsp(3'b010),      write_rsp(3'b001),                 WR_AP1, 3'd0, 32'h0,         1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd2, 32'h000000F1,  0,  write_rsp(3'b010),      write_rsp(3'b001),                 WR_DP2, 3'd0, 32'h0,         1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         16, read_rsp(3'b010, 0, 0), read_rsp(3'b001, 32'hDEADBEEF, 0), RD_DP0, 3'd1, 32'h0,         16};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         3,  read_rsp(3'b010, 0, 0), read_rsp(3'b001, 32'h12345678, 0), RD_DP0, 3'd0, 32'h12345678, 4};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h0,         0,  read_rsp(3'b010, 0, 0), read_rsp(3'b001, 32'hA5A5F00F, 1), RD_AP3, 3'd3, 32'h0,         1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2, 32'h000000F1,  0,  write_rsp(3'b010),      write_rsp(3'b100),                 WR_DP2, 3'd2, 32'h0,         1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h0,         0,  read_rsp(3'b010, 0, 0), read_rsp(3'b111, 32'h0F0F0F0F, 0), RD_AP3, 3'd4, 32'h0,         1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         0,  read_rsp(3'b010, 0, 0), write_rsp(3'b001),                 RD_DP0, 3'd4, 32'h0,         1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h23000052,  2,  write_rsp(3'b010),      write_rsp(3'b001),                 WR_AP1, 3'd0, 32'h0,         3};

    @(negedge CLK);
    checkOutput("reset REQ_READY", 82'(REQ_READY), 82'(1));
    checkOutput("reset RSP_VALID", 82'(RSP_VALID), 82'(0));
    checkOutput("reset RSP_STATUS", 82'(RSP_STATUS), 82'(0));
    checkOutput("reset RSP_RDATA", 82'(RSP_RDATA), 82'(0));
    checkOutput("reset PHY_WREN", 82'(PHY_WREN), 82'(0));
    checkOutput("reset PHY_RDEN", 82'(PHY_RDEN), 82'(0));
    checkOutput("reset PHY_WRDATA", PHY_WRDATA, 82'(0));
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 11; i++) applyStimulus(i);

    // Command FIFO full for 10 cycles while the controller sits in ISSUE.
    PHY_WRFULL = 1'b1;
    send_req("full", 1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
    early = 0;
    repeat (10) begin
      @(negedge CLK);
      if (PHY_WREN) early++;
    end
    checkOutput("full no push", 82'(early), 82'(0));
    PHY_WRFULL = 1'b0;
    service_txn("full", 0, '0, read_rsp(3'b001, 32'hCAFEF00D, 0), RD_DP0, 1'b0,
                pushes, first_cyc, rsp_cyc, rdens);
    checkOutput("full pushes", 82'(pushes), 82'(1));
    checkOutput("full push after release", 82'(first_cyc), 82'(0));
    checkOutput("full status", 82'(RSP_STATUS), 82'(0));
    checkOutput("full rdata", 82'(RSP_RDATA), 82'(32'hCAFEF00D));
    complete_rsp("full");

    // Reset while waiting for a response that never arrives.
    send_req("rst", 1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (PHY_WREN) seen = 1;
    end
    checkOutput("rst push", 82'(seen), 82'(1));
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checkOutput("rst REQ_READY", 82'(REQ_READY), 82'(1));
    checkOutput("rst RSP_VALID", 82'(RSP_VALID), 82'(0));
    checkOutput("rst RSP_STATUS", 82'(RSP_STATUS), 82'(0));
    checkOutput("rst RSP_RDATA", 82'(RSP_RDATA), 82'(0));
    checkOutput("rst PHY_WREN", 82'(PHY_WREN), 82'(0));
    checkOutput("rst PHY_RDEN", 82'(PHY_RDEN), 82'(0));
    checkOutput("rst PHY_WRDATA", PHY_WRDATA, 82'(0));
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rst ready after", 82'(REQ_READY), 82'(1));
    applyStimulus(0);

    // RSP_READY already high when the result appears: one-cycle completion.
    RSP_READY = 1'b1;
    send_req("fast", 1'b0, 1'b1, 1'b0, 2'd1, 32'h23000052);
    service_txn("fast", 0, '0, write_rsp(3'b001), WR_AP1, 1'b0, pushes, first_cyc, rsp_cyc, rdens);
    checkOutput("fast status", 82'(RSP_STATUS), 82'(0));
    @(negedge CLK);
    checkOutput("fast rsp cleared", 82'(RSP_VALID), 82'(0));
    checkOutput("fast ready", 82'(REQ_READY), 82'(1));
    RSP_READY = 1'b0;

    repeat (2) @(negedge CLK);
    checkOutput("fifo protocol violations", 82'(proto_err), 82'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/swd_txn_ctrl.md
Name: swd_txn_ctrl

Overview:
- Transaction sequencer sitting between the bus-side debug logic and the SWD PHY command/response FIFOs.
- Accepts DP/AP register read/write requests and encodes each as one PHY command word {len, t0, t1, so}.
- Decodes the PHY response word, checks ACK and read parity, and retries on WAIT up to a limit.
- Also issues SWD line-reset sequences. Exactly one transaction is outstanding at a time.

Parameters:
OWIDTH, 64, PHY serial-out width; command word width OWIDTH+3*$clog2(OWIDTH) = 82
IWIDTH, 38, PHY capture width; response word width IWIDTH+$clog2(IWIDTH)-1 = 43
RETRY_MAX, 15, WAIT retries before reporting failure (4-bit counter)

Ports:
CLK  in  1  system clock (same domain as the PHY FIFO interface side)
RESET  in  1  asynchronous, active-high reset
REQ_VALID  in  1  request strobe
REQ_READY  out  1  controller idle, request accepted when VALID&READY
REQ_LINERST  in  1  request is a line reset; other REQ fields are ignored
REQ_APNDP  in  1  1=AP, 0=DP
REQ_RNW  in  1  1=read
REQ_ADDR  in  2  A[3:2]
REQ_WDATA  in  32  write data
RSP_VALID  out  1  result valid, held until RSP_READY
RSP_READY  in  1  result consumed
RSP_STATUS  out  3  0=OK, 1=WAIT exhausted, 2=FAULT, 3=parity error, 4=no/invalid ACK
RSP_RDATA  out  32  read data (0 for writes and errors)
PHY_WRDATA  out  82  command word {len[5:0], t0[5:0], t1[5:0], so[63:0]}
PHY_WREN  out  1  single-cycle push
PHY_WRFULL  in  1  command FIFO full
PHY_RDDATA  in  43  response word {bits[36:0], cnt[5:0]}
PHY_RDEN  out  1  single-cycle pop
PHY_RDEMPTY  in  1  response FIFO empty

Behaviour:
- Reset (async, RESET=1): state IDLE; REQ_READY=1; RSP_VALID=0; RSP_STATUS=0; RSP_RDATA=0; PHY_WREN=0; PHY_RDEN=0; PHY_WRDATA=0; retry counter=0. Reset mid-transaction abandons it; any late PHY response is dropped by the PHY FIFO reset.
- Header: so[7:0] = {park=1, stop=0, parity, A3, A2, RnW, APnDP, start=1}, sent LSB first. Parity is the XOR of APnDP, RnW, A2, A3.
- Read command: len=46, t0=8, t1=45, so[63:8]=0.
- Write command: len=46, t0=8, t1=12, so[45:13]={^WDATA, WDATA}, with WDATA[0] at bit 13. All other bits are 0.
- Line reset command: len=60, t0=63, t1=63, so[51:0]=all 1, so[63:52]=0. No response is expected and the PHY writes none.
- FSM:
  - IDLE: on VALID&READY, latch request, drop READY -> ISSUE.
  - ISSUE: wait until !PHY_WRFULL, then pulse PHY_WREN for 1 cycle with PHY_WRDATA stable that cycle. Line reset -> DONE with status 0. Otherwise -> WAITRSP.
  - WAITRSP: when !PHY_RDEMPTY, pulse PHY_RDEN for 1 cycle and register PHY_RDDATA on the following cycle -> DECODE.
  - DECODE:
    - ack = {bits[33],bits[34],bits[35]} for reads (cnt=36); ack = bits[2:0] reordered likewise for writes (cnt=3).
    - cnt mismatch, or ack not 001/010/100 -> DONE, status 4.
    - 100 -> DONE, status 2.
    - 010: if retries < RETRY_MAX, increment and -> ISSUE (same command); else -> DONE, status 1.
    - 001 on read: data = bit-reverse(bits[32:1]), parity = bits[0]. Mismatch with ^data -> status 3, else status 0 with RSP_RDATA = data.
    - 001 on write: status 0.
  - DONE: RSP_VALID=1; on RSP_READY clear RSP_VALID and retries, set REQ_READY -> IDLE. RSP_VALID and RSP_READY in the same cycle completes in 1 cycle.
- Minimum request-to-command latency is 2 cycles (accept, then ISSUE push). PHY_WREN is never asserted while PHY_WRFULL=1.
- PHY_RDEN is never asserted while PHY_RDEMPTY=1.
- REQ_VALID while not ready is ignored and held by the requester.

Test Plan:
1. DP read addr 0 (IDCODE), PHY returns ack 001, data 0x2BA01477, correct parity -> command len=46, t0=8, t1=45, so[7:0]=0xA5; RSP_STATUS=0, RSP_RDATA=0x2BA01477.
2. AP write addr 1, data 0x23000052, ack 001 -> so[7:0]=0x8B (after parity recomputation), so[44:13]=0x23000052, so[45]=parity; status 0, RSP_RDATA=0.
3. DP read with WAIT returned 3 times then OK -> exactly 4 PHY_WREN pulses, identical PHY_WRDATA each time, status 0. WAIT returned 16 times -> 16 pushes, status 1.
4. Read returning OK with flipped parity bit -> status 3, RSP_RDATA=0. FAULT ack -> status 2. Ack 111 -> status 4.
5. Line reset request -> one command with len=60, so=0x000F_FFFF_FFFF_FFFF, no PHY_RDEN, RSP_VALID within 3 cycles.
6. PHY_WRFULL held 10 cycles during ISSUE -> no push until release. Assert RESET in WAITRSP -> all outputs return to reset values immediately and REQ_READY=1 after deassertion.
